// File: rtl/div_seq_ctrl.sv
// Sequencing FSM for a restoring shift-subtract divider: load, WIDTH shift/decide
// iterations, then a done pulse, with divide-by-zero detection and abort.
module div_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          div_zero,
    input  logic          rem_neg,
    output logic          busy,
    output logic          load,
    output logic          shift_en,
    output logic          q_we,
    output logic          q_bit,
    output logic          restore,
    output logic          done,
    output logic          dbz,
    output logic [CW-1:0] iter_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          w_accept;
    logic          w_abort;
    logic          w_cnt_zero;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    assign w_abort    = (r_state != S_IDLE) && abort;
    assign w_cnt_zero = (r_cnt == '0);

    // Abort overrides every transition, including the ones into DONE.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) w_state_nxt = S_LOAD;
                S_LOAD:   w_state_nxt = div_zero ? S_DONE : S_SHIFT;
                S_SHIFT:  w_state_nxt = S_DECIDE;
                S_DECIDE: w_state_nxt = w_cnt_zero ? S_DONE : S_SHIFT;
                S_DONE:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_INIT;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept || w_abort) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == S_DECIDE && !w_cnt_zero) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_accept) begin
                r_dbz <= 1'b0;
            end else if (r_state == S_LOAD && !abort && div_zero) begin
                r_dbz <= 1'b1;
            end
        end
    end

    // Moore strobes; q_bit and restore follow rem_neg combinationally in DECIDE.
    assign busy     = (r_state != S_IDLE);
    assign load     = (r_state == S_LOAD);
    assign shift_en = (r_state == S_SHIFT);
    assign q_we     = (r_state == S_DECIDE);
    assign q_bit    = (r_state == S_DECIDE) && !rem_neg;
    assign restore  = (r_state == S_DECIDE) && rem_neg;
    assign done     = (r_state == S_DONE);
    assign dbz      = r_dbz;
    assign iter_cnt = r_cnt;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, timed sequences,
// and random stimulus against a cycle-position reference model.
module tb_div_seq_ctrl;

    localparam int W  = 16;
    localparam int CW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          div_zero;
    logic          rem_neg;
    logic          busy;
    logic          load;
    logic          shift_en;
    logic          q_we;
    logic          q_bit;
    logic          restore;
    logic          done;
    logic          dbz;
    logic [CW-1:0] iter_cnt;

    div_seq_ctrl #(.WIDTH(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .div_zero (div_zero),
        .rem_neg  (rem_neg),
        .busy     (busy),
        .load     (load),
        .shift_en (shift_en),
        .q_we     (q_we),
        .q_bit    (q_bit),
        .restore  (restore),
        .done     (done),
        .dbz      (dbz),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: m_k counts cycles since the accepted start (0 = idle).
    int   m_k;
    logic m_dz;
    logic m_dbz;
    int   m_idle_cnt;

    task automatic model_reset();
        m_k = 0; m_dz = 1'b0; m_dbz = 1'b0; m_idle_cnt = W - 1;
    endtask

    function automatic int final_k();
        return m_dz ? 2 : 2 * W + 2;
    endfunction

    function automatic logic [7:0] exp_flags();
        logic ld, sh, dc, dn;
        ld = (m_k == 1);
        sh = !m_dz && m_k >= 2 && m_k <= 2 * W && (m_k % 2 == 0);
        dc = !m_dz && m_k >= 3 && m_k <= 2 * W + 1 && (m_k % 2 == 1);
        dn = (m_k != 0) && (m_k == final_k());
        return {m_k != 0, ld, sh, dc, dc & ~rem_neg, dc & rem_neg, dn, m_dbz};
    endfunction

    function automatic int exp_cnt();
        if (m_k == 0) return m_idle_cnt;
        if (m_dz || m_k <= 2) return W - 1;
        if (m_k == 2 * W + 2) return 0;
        return W - 1 - (m_k - 2) / 2;
    endfunction

    task automatic model_update();
        if (m_k == 0) begin
            if (start && !abort) begin m_k = 1; m_dz = 1'b0; m_dbz = 1'b0; end
        end else if (abort) begin
            m_k = 0; m_idle_cnt = W - 1;
        end else if (m_k == final_k()) begin
            m_idle_cnt = m_dz ? W - 1 : 0;
            m_k = 0;
        end else begin
            if (m_k == 1 && div_zero) begin m_dz = 1'b1; m_dbz = 1'b1; end
            m_k++;
        end
    endtask

    function automatic logic [7:0] act_flags();
        return {busy, load, shift_en, q_we, q_bit, restore, done, dbz};
    endfunction

    int cyc;
    int done_cyc[$];

    task automatic drive(input logic s, input logic a, input logic dz, input logic rn);
        @(negedge clk);
        start = s; abort = a; div_zero = dz; rem_neg = rn;
        #1;
    endtask

    task automatic advance();
        if (done === 1'b1) done_cyc.push_back(cyc);
        @(posedge clk);
        model_update();
        cyc++;
    endtask

    task automatic step(input logic s, input logic a, input logic dz, input logic rn);
        drive(s, a, dz, rn);
        check("flags", act_flags(), exp_flags());
        check("iter_cnt", iter_cnt, exp_cnt());
        advance();
    endtask

    task automatic begin_seq();
        cyc = 0;
        done_cyc.delete();
    endtask

    typedef struct {
        logic       s, a, dz, rn;
        logic [7:0] flags;   // {busy,load,shift_en,q_we,q_bit,restore,done,dbz}
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 4'd15}; // idle, start accepted
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'b1100_0000, 4'd15}; // load, divisor zero
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b1000_0011, 4'd15}; // done with dbz, start ignored
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, 4'd15}; // dbz held in idle
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0001, 4'd15}; // start+abort ignored
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, 4'd15}; // still idle
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0000_0001, 4'd15}; // start accepted
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b1100_0000, 4'd15}; // load, dbz cleared
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1010_0000, 4'd15}; // shift, rem_neg ignored
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'b1001_0100, 4'd15}; // decide, restore
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b1010_0000, 4'd14}; // shift, abort
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 4'd15}; // idle, counter reloaded

        rst = 1'b1; start = 1'b0; abort = 1'b0; div_zero = 1'b0; rem_neg = 1'b0;
        model_reset();
        #2;
        check("reset_flags", act_flags(), 8'h00);
        check("reset_cnt", iter_cnt, 64'(W - 1));
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        begin_seq();
        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].a, vecs[i].dz, vecs[i].rn);
            check($sformatf("vec%0d_flags", i), act_flags(), vecs[i].flags);
            check($sformatf("vec%0d_cnt", i), iter_cnt, vecs[i].cnt);
            advance();
        end

        // Full operation, rem_neg alternating 1,0 per DECIDE.
        begin_seq();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 35; c++) step(1'b0, 1'b0, 1'b0, ((c >> 1) & 1) == 1);
        check("full_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check("full_done_cycle", done_cyc[0], 34);

        // Abort during SHIFT at cycle 20, restart at cycle 21.
        begin_seq();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_cnt", iter_cnt, 64'(W - 1));
        advance();
        for (int c = 22; c <= 56; c++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
        check("abort_restart_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check("abort_restart_cycle", done_cyc[0], 55);

        // Abort in the final DECIDE.
        begin_seq();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 32; c++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 34; c <= 36; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("final_abort_no_done", done_cyc.size(), 0);

        // start held continuously: back-to-back operations.
        begin_seq();
        for (int c = 0; c <= 70; c++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 1));
        check("b2b_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) begin
            check("b2b_done0", done_cyc[0], 34);
            check("b2b_done1", done_cyc[1], 69);
        end
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, mid-iteration.
        begin_seq();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_flags", act_flags(), 8'h00);
        check("async_rst_cnt", iter_cnt, 64'(W - 1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        begin_seq();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 35; c++) step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
        check("post_rst_done_count", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check("post_rst_done_cycle", done_cyc[0], 34);

        // Random stimulus against the reference model.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
